// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared encodings for the fetch PC generator.
// npc_op codes, FSM state encoding, exception vector and a small alignment helper.
package pc_gen_pkg;

  localparam int NPC_OP_W_DEF = 3;

  // npc_op encoding; codes 5..7 behave as NPC_NORMAL.
  localparam logic [2:0] NPC_NORMAL = 3'd0;
  localparam logic [2:0] NPC_BR     = 3'd1;
  localparam logic [2:0] NPC_JR     = 3'd2;
  localparam logic [2:0] NPC_JAL    = 3'd3;
  localparam logic [2:0] NPC_J      = 3'd4;

  // BOOT: first cycle out of reset, RUN: sequential fetch, PEND: target held in pend_pc.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } pc_state_e;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  // A target is misaligned when its two low bits are not both zero.
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch request channel between pc_gen and instruction memory.
// Handshake: fetch_pc is a request whenever fetch_valid is high; it is accepted
// on a rising edge where fetch_valid & fetch_ready are both high, and fetch_pc
// does not change while fetch_valid is high and fetch_ready is low.
interface pc_gen_if #(
  parameter int XLEN = 32
) ();
  logic            fetch_valid;
  logic            fetch_ready;
  logic [XLEN-1:0] fetch_pc;

  modport master (output fetch_valid, output fetch_pc, input fetch_ready);
  modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_gen_npc_target.sv
// npc_target: combinational redirect target, JAL link address,
// redirect-active decode and target misalignment detection.
module npc_target
  import pc_gen_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NPC_OP_W = 3
) (
  input  logic                redir_valid,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                br_taken,
  input  logic [XLEN-1:0]     pc_d,
  input  logic [15:0]         imm16,
  input  logic [25:0]         imm26,
  input  logic [XLEN-1:0]     rs_val,
  output logic [XLEN-1:0]     target,
  output logic [XLEN-1:0]     link_pc,
  output logic                redir_active,
  output logic                misaligned
);

  logic [XLEN-1:0] br_off;

  // Sign-extended word offset of a branch, already shifted to a byte offset.
  assign br_off  = {{(XLEN-18){imm16[15]}}, imm16, 2'b00};
  assign link_pc = pc_d + XLEN'(8);

  // Decode the op into a target and whether it redirects fetch at all.
  always_comb begin
    target       = pc_d + XLEN'(4);
    redir_active = 1'b0;
    case (npc_op)
      NPC_OP_W'(NPC_BR): begin
        target       = pc_d + XLEN'(4) + br_off;
        redir_active = redir_valid & br_taken;
      end
      NPC_OP_W'(NPC_JR): begin
        target       = rs_val;
        redir_active = redir_valid;
      end
      NPC_OP_W'(NPC_JAL), NPC_OP_W'(NPC_J): begin
        target       = {pc_d[XLEN-1:28], imm26, 2'b00};
        redir_active = redir_valid;
      end
      default: begin
        target       = pc_d + XLEN'(4);
        redir_active = 1'b0;
      end
    endcase
  end

  assign misaligned = is_misaligned(target[1:0]);

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register and redirect FSM (BOOT/RUN/PEND).
// A redirect that cannot be applied because fetch did not advance is held in
// pend_pc until the next advance; a newer redirect replaces it.
// Optional macro PC_GEN_EXC_EN adds exc_req/eret_req/epc, which take priority
// over decode redirects (exception vector first, then epc).
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          NPC_OP_W = NPC_OP_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  pc_gen_if.master            fetch,
  input  logic                redir_valid,
  input  logic [NPC_OP_W-1:0] npc_op,
  input  logic                br_taken,
  input  logic [XLEN-1:0]     pc_d,
  input  logic [15:0]         imm16,
  input  logic [25:0]         imm26,
  input  logic [XLEN-1:0]     rs_val,
  output logic [XLEN-1:0]     link_pc,
  output logic                pend_valid,
  output logic                addr_err,
`ifdef PC_GEN_EXC_EN
  input  logic                exc_req,
  input  logic                eret_req,
  input  logic [XLEN-1:0]     epc,
`endif
  output pc_state_e           dbg_state
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            addr_err_q, addr_err_d;

  logic [XLEN-1:0] npc_tgt;
  logic            npc_active;
  logic            npc_misal;
  logic [XLEN-1:0] sel_target;
  logic            sel_active;
  logic            sel_misal;
  logic            fetch_valid;
  logic            advance;

  npc_target #(
    .XLEN     (XLEN),
    .NPC_OP_W (NPC_OP_W)
  ) u_npc_target (
    .redir_valid  (redir_valid),
    .npc_op       (npc_op),
    .br_taken     (br_taken),
    .pc_d         (pc_d),
    .imm16        (imm16),
    .imm26        (imm26),
    .rs_val       (rs_val),
    .target       (npc_tgt),
    .link_pc      (link_pc),
    .redir_active (npc_active),
    .misaligned   (npc_misal)
  );

  assign fetch_valid = (state_q != ST_BOOT);
  assign advance     = fetch_valid & fetch.fetch_ready & ~stall;

  // Pick the winning redirect source for this cycle.
  always_comb begin
    sel_target = npc_tgt;
    sel_active = npc_active;
    sel_misal  = npc_misal;
`ifdef PC_GEN_EXC_EN
    if (exc_req) begin
      sel_target = XLEN'(EXC_VECTOR);
      sel_active = 1'b1;
      sel_misal  = is_misaligned(EXC_VECTOR[1:0]);
    end else if (eret_req) begin
      sel_target = epc;
      sel_active = 1'b1;
      sel_misal  = is_misaligned(epc[1:0]);
    end
`endif
  end

  // Next-state and register update: apply, hold, or advance the fetch PC.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    pend_pc_d  = pend_pc_q;
    addr_err_d = addr_err_q;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sel_active) begin
          addr_err_d = addr_err_q | sel_misal;
          if (advance) begin
            fetch_pc_d = sel_target;
          end else begin
            pend_pc_d = sel_target;
            state_d   = ST_PEND;
          end
        end else if (advance) begin
          fetch_pc_d = fetch_pc_q + XLEN'(4);
        end
      end
      ST_PEND: begin
        if (sel_active) begin
          addr_err_d = addr_err_q | sel_misal;
          if (advance) fetch_pc_d = sel_target;
          else         pend_pc_d  = sel_target;
        end else if (advance) begin
          fetch_pc_d = pend_pc_q;
        end
        if (advance) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  // State and PC registers; reset discards any pending redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_BOOT;
      fetch_pc_q <= XLEN'(RESET_PC);
      pend_pc_q  <= XLEN'(RESET_PC);
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pend_pc_q  <= pend_pc_d;
      addr_err_q <= addr_err_d;
    end
  end

  assign fetch.fetch_valid = fetch_valid;
  assign fetch.fetch_pc    = fetch_pc_q;
  assign pend_valid        = (state_q == ST_PEND);
  assign addr_err          = addr_err_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized traffic for pc_gen, checked
// against a behavioural model of the fetch address stream.
module tb_pc_gen;
  import pc_gen_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        stall, rv, bt;
  logic [2:0]  op;
  logic [31:0] pcd, rs;
  logic [15:0] i16;
  logic [25:0] i26;
  logic [31:0] link_pc;
  logic        pend_valid, addr_err;
  pc_state_e   dbg_state;

  pc_gen_if #(.XLEN(32)) fif ();

`ifdef PC_GEN_EXC_EN
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'h0;
`endif

  pc_gen #(.XLEN(32), .RESET_PC(RST_PC), .NPC_OP_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .fetch       (fif.master),
    .redir_valid (rv),
    .npc_op      (op),
    .br_taken    (bt),
    .pc_d        (pcd),
    .imm16       (i16),
    .imm26       (i26),
    .rs_val      (rs),
    .link_pc     (link_pc),
    .pend_valid  (pend_valid),
    .addr_err    (addr_err),
`ifdef PC_GEN_EXC_EN
    .exc_req     (exc_req),
    .eret_req    (eret_req),
    .epc         (epc),
`endif
    .dbg_state   (dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // The fetch stream: after reset one idle cycle, then each accepted fetch is
  // followed by the newest outstanding redirect target, or the next word.
  logic [31:0] exp_q[$];   // outstanding redirect target (newest only)
  bit          m_booted;
  logic [31:0] m_pc;
  bit          m_err;

  function automatic bit model_active();
    if (!rv) return 0;
    return (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd1 && bt);
  endfunction

  function automatic logic [31:0] model_target();
    int off;
    off = $signed(i16);
    case (op)
      3'd1:    return pcd + 32'd4 + 32'(off * 4);
      3'd2:    return rs;
      default: return (pcd & 32'hF000_0000) + (32'(i26) * 32'd4);
    endcase
  endfunction

  function automatic void model_reset();
    m_booted = 0;
    m_pc     = RST_PC;
    m_err    = 0;
    exp_q.delete();
  endfunction

  function automatic void model_update();
    bit          adv;
    logic [31:0] t;
    adv = m_booted && fif.fetch_ready && !stall;
    if (!m_booted) begin
      m_booted = 1;
      return;
    end
    if (model_active()) begin
      t = model_target();
      if (t % 4 != 0) m_err = 1;
      exp_q.delete();
      if (adv) m_pc = t;
      else     exp_q.push_back(t);
    end else if (adv) begin
      if (exp_q.size() != 0) m_pc = exp_q.pop_front();
      else                   m_pc = m_pc + 32'd4;
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    stall = 1'b0; fif.fetch_ready = 1'b1; rv = 1'b0; op = 3'd0; bt = 1'b0;
    pcd = 32'h0; i16 = 16'h0; i26 = 26'h0; rs = 32'h0;
  endtask

  task automatic redir(input logic [2:0] o, input logic b, input logic [31:0] p,
                       input logic [15:0] s, input logic [25:0] j, input logic [31:0] r);
    rv = 1'b1; op = o; bt = b; pcd = p; i16 = s; i26 = j; rs = r;
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (fif.fetch_pc !== RST_PC || fif.fetch_valid !== 1'b0 || pend_valid !== 1'b0 || addr_err !== 1'b0)
      $display("FAIL reset_values: pc=%h valid=%b pend=%b err=%b want pc=%h 0 0 0",
               fif.fetch_pc, fif.fetch_valid, pend_valid, addr_err, RST_PC);
    else n_pass++;
    release_reset();
    n_checks++;
    if (fif.fetch_valid !== 1'b0) $display("FAIL boot_valid: got %b want 0", fif.fetch_valid);
    else n_pass++;
    exp_q.delete();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (fif.fetch_valid !== 1'b1 || fif.fetch_pc !== RST_PC + 32'(4 * i))
        $display("FAIL seq_%0d: valid=%b pc=%h want 1 %h", i, fif.fetch_valid, fif.fetch_pc, RST_PC + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_branch();
    redir(3'd1, 1'b1, 32'h0000_3004, 16'hFFFF, 26'h0, 32'h0);
    #1;
    n_checks++;
    if (link_pc !== 32'h0000_300C) $display("FAIL br_link: got %h want 0000300c", link_pc);
    else n_pass++;
    step();
    n_checks++;
    if (fif.fetch_pc !== 32'h0000_3004 || fif.fetch_pc !== m_pc)
      $display("FAIL br_taken: got %h want 00003004 (model %h)", fif.fetch_pc, m_pc);
    else n_pass++;
    idle();
  endtask

  task automatic test_jr_pending();
    logic [31:0] held;
    held = fif.fetch_pc;
    fif.fetch_ready = 1'b0;
    redir(3'd2, 1'b0, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3100);
    for (int i = 0; i < 3; i++) begin
      step();
      rv = 1'b0;
      n_checks++;
      if (pend_valid !== 1'b1 || fif.fetch_pc !== held)
        $display("FAIL jr_hold_%0d: pend=%b pc=%h want 1 %h", i, pend_valid, fif.fetch_pc, held);
      else n_pass++;
    end
    fif.fetch_ready = 1'b1;
    step();
    n_checks++;
    if (fif.fetch_pc !== 32'h0000_3100 || pend_valid !== 1'b0)
      $display("FAIL jr_apply: pc=%h pend=%b want 00003100 0", fif.fetch_pc, pend_valid);
    else n_pass++;
    idle();
  endtask

  task automatic test_newest_wins();
    stall = 1'b1;
    redir(3'd4, 1'b0, 32'h0000_3000, 26'h0000C10, 26'h0000C10, 32'h0);
    i16 = 16'h0;
    step();
    redir(3'd2, 1'b0, 32'h0000_3004, 16'h0, 26'h0, 32'h0000_3200);
    step();
    rv = 1'b0;
    stall = 1'b0;
    step();
    n_checks++;
    if (fif.fetch_pc !== 32'h0000_3200 || pend_valid !== 1'b0)
      $display("FAIL newest_wins: pc=%h pend=%b want 00003200 0", fif.fetch_pc, pend_valid);
    else n_pass++;
    idle();
  endtask

  task automatic test_misalign();
    redir(3'd2, 1'b0, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3102);
    step();
    idle();
    n_checks++;
    if (addr_err !== 1'b1 || fif.fetch_pc !== 32'h0000_3102)
      $display("FAIL misalign: err=%b pc=%h want 1 00003102", addr_err, fif.fetch_pc);
    else n_pass++;
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (addr_err !== 1'b1) $display("FAIL err_sticky: got %b want 1", addr_err);
    else n_pass++;
  endtask

  task automatic test_reset_in_pend();
    fif.fetch_ready = 1'b0;
    redir(3'd2, 1'b0, 32'h0000_3000, 16'h0, 26'h0, 32'h0000_3300);
    step();
    rv = 1'b0;
    n_checks++;
    if (pend_valid !== 1'b1) $display("FAIL pend_before_reset: got %b want 1", pend_valid);
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_checks++;
    if (fif.fetch_pc !== RST_PC || pend_valid !== 1'b0 || addr_err !== 1'b0 || fif.fetch_valid !== 1'b0)
      $display("FAIL async_reset: pc=%h pend=%b err=%b valid=%b want %h 0 0 0",
               fif.fetch_pc, pend_valid, addr_err, fif.fetch_valid, RST_PC);
    else n_pass++;
    idle();
    release_reset();
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (fif.fetch_pc !== RST_PC + 32'(4 * i) || pend_valid !== 1'b0)
        $display("FAIL no_stale_%0d: pc=%h pend=%b want %h 0", i, fif.fetch_pc, pend_valid, RST_PC + 32'(4 * i));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      stall           = ($urandom_range(0, 4) == 0);
      fif.fetch_ready = ($urandom_range(0, 9) < 7);
      rv              = ($urandom_range(0, 2) == 0);
      op              = 3'($urandom_range(0, 7));
      bt              = 1'($urandom_range(0, 1));
      pcd             = {4'($urandom_range(0, 15)), 16'h0, 10'($urandom), 2'b00};
      i16             = 16'($urandom);
      i26             = 26'($urandom);
      rs              = {$urandom} & (($urandom_range(0, 9) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      #1;
      n_checks++;
      if (link_pc !== pcd + 32'd8) $display("FAIL rnd_link_%0d: got %h want %h", c, link_pc, pcd + 32'd8);
      else n_pass++;
      step();
      n_checks++;
      if (fif.fetch_pc !== m_pc || fif.fetch_valid !== 1'b1 ||
          pend_valid !== (exp_q.size() != 0) || addr_err !== m_err)
        $display("FAIL rnd_%0d: pc=%h pend=%b err=%b want pc=%h pend=%b err=%b",
                 c, fif.fetch_pc, pend_valid, addr_err, m_pc, (exp_q.size() != 0), m_err);
      else n_pass++;
    end
    idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    model_reset();
    test_reset();
    test_branch();
    test_jr_pending();
    test_newest_wins();
    test_misalign();
    test_reset_in_pend();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
